pmp_multi_checker: RTL and testbench
====================================

// Module: pmp_multi_checker
// PURPOSE
// Multi-entry PMP access checker for the RISC-V core's load/store/fetch paths.
// Accepts one access per valid/ready handshake and scans ENTRIES PMP entries
// sequentially, one per cycle. The lowest-numbered entry that touches the access
// decides the result, so the scan stops at that entry.
// Supports OFF/TOR/NA4/NAPOT address modes, enforces R/W/X and lock (L) bits, and
// returns allow/deny plus the deciding entry index. It sits between the LSU/IFU
// request and the bus; a denied access raises an access fault upstream.
// PARAMETERS
// XLEN     32                   address / pmpaddr width
// ENTRIES  16                   number of PMP entries (1..64)
// IDX_W    $clog2(ENTRIES)+1    width of resp_idx
// PORTS
// clk        in   1             clock
// rst        in   1             synchronous, active-high reset
// req_valid  in   1             access request valid
// req_ready  out  1             checker idle, can accept a request
// req_addr   in   XLEN          byte address of the access
// req_size   in   2             00 byte, 01 half, 10 word, 11 dword (8 B)
// req_type   in   2             00 read, 01 write, 10 execute, 11 reserved (deny)
// req_priv_m in   1             1 = machine mode
// pmpcfg     in   8*ENTRIES     entry i in [8i+7:8i]: L[7], A[4:3], X[2], W[1], R[0]
// pmpaddr    in   XLEN*ENTRIES  entry i in [XLEN*i +: XLEN]; encodes addr bits [XLEN+1:2]
// resp_valid out  1             result valid, held until resp_ready
// resp_ready in   1             consumer accepts the result
// resp_allow out  1             1 = access permitted
// resp_match out  1             1 = some entry decided; 0 = no entry touched the access
// resp_idx   out  IDX_W         deciding entry index; ENTRIES when resp_match=0
// BEHAVIOUR
// - Reset: state IDLE, req_ready=1, resp_valid=0, resp_allow=0, resp_match=0,
//   resp_idx=0, scan index=0. Reset mid-scan or while in DONE abandons the request;
//   no response is produced.
// - FSM IDLE -> SCAN -> DONE -> IDLE.
//   - req_ready = (state==IDLE).
//   - In IDLE, req_valid at a clock edge latches addr/size/type/priv and moves to
//     SCAN with idx=0.
//   - In SCAN, entry idx is evaluated combinationally each cycle. If it decides,
//     the outputs are registered and the FSM moves to DONE. Otherwise idx
//     increments. When idx==ENTRIES-1 and that entry does not decide, the
//     no-match result is registered and the FSM moves to DONE.
//   - In DONE, resp_valid=1 and the outputs are stable. resp_ready at the edge
//     returns to IDLE. A new request cannot be accepted in the same cycle.
// - Latency: when entry i decides, resp_valid rises i+2 edges after the accept edge.
//   With no match it rises ENTRIES+1 edges after the accept edge.
// - pmpcfg/pmpaddr are sampled live each SCAN cycle. The integrator holds them
//   stable during a scan; they are not snapshotted.
// - Arithmetic is done in XLEN+3 bits, so there is no wrap-around.
//   - lo_acc = req_addr; hi_acc = req_addr + (1<<req_size) - 1.
//   - Region is [lo, hi] inclusive.
//   - NA4: lo = pmpaddr<<2, hi = lo+3.
//   - NAPOT: k = number of trailing ones of pmpaddr; lo = (pmpaddr & ~(2^(k+1)-1))<<2;
//     hi = lo + 2^(k+3) - 1. All-ones pmpaddr (k=XLEN) covers the whole space.
//   - TOR: lo = pmpaddr[i-1]<<2 (0 for entry 0), hi = (pmpaddr[i]<<2) - 1.
//     If pmpaddr[i-1] >= pmpaddr[i], the region is empty.
//   - OFF entries never decide.
// - Decision rules:
//   - Full containment (lo<=lo_acc && hi_acc<=hi) means the entry matches.
//   - Partial overlap (some bytes in, some out) also decides: resp_match=1 and
//     resp_allow=0.
//   - On a full match: if L=0 and req_priv_m=1, allow. Otherwise allow iff the
//     R/W/X bit selected by req_type is set. req_type=11 is always denied.
//   - No match: resp_allow = req_priv_m && req_type!=11.
// TESTING
// - T1: entry0 NAPOT pmpaddr=0x2000_03FF (0x8000_0000..0x8000_1FFF, R=1 W=0 X=0),
//   priv U, read word @0x8000_1FFC
//   -> resp_match=1, allow=1, idx=0, latency 2.
// - T2: same entry, read word @0x8000_1FFE (straddles the top of the region)
//   -> match=1, allow=0, idx=0.
// - T3: entry3 TOR pmpaddr[2]=0x0000_0400, pmpaddr[3]=0x0000_0800 (0x1000..0x1FFF,
//   RWX=111), entries 0-2 OFF, write byte @0x1FFF
//   -> allow=1, idx=3, latency 5.
// - T4: all 16 entries OFF. Priv M read
//   -> match=0, allow=1, idx=16, latency 17. Priv U
//   -> allow=0.
// - T5: entries 1 and 5 both NAPOT covering @0x100; entry1 R=0 with L=1, entry5
//   R=1; priv M read @0x100
//   -> idx=1, allow=0 (lowest entry wins, lock applies to M).
// - T6: hold resp_ready=0 for 4 cycles
//   -> resp_* stable and req_ready=0. Also assert rst during SCAN
//   -> next cycle req_ready=1, resp_valid=0.

Source files
------------

// File: rtl/pmp_multi_checker_if.sv
// Request/response bundle between an LSU/IFU requester and the PMP checker.
// The requester side uses the master modport; the checker uses slave.
interface pmp_multi_checker_if #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES) + 1
);
    logic             req_valid;
    logic             req_ready;
    logic [XLEN-1:0]  req_addr;
    logic [1:0]       req_size;
    logic [1:0]       req_type;
    logic             req_priv_m;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_allow;
    logic             resp_match;
    logic [IDX_W-1:0] resp_idx;

    modport master (
        output req_valid, req_addr, req_size, req_type, req_priv_m, resp_ready,
        input  req_ready, resp_valid, resp_allow, resp_match, resp_idx
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_type, req_priv_m, resp_ready,
        output req_ready, resp_valid, resp_allow, resp_match, resp_idx
    );
endinterface

// File: rtl/pmp_multi_checker.sv
// Sequential multi-entry PMP checker: one entry evaluated per cycle, the
// lowest-numbered entry that touches the access decides allow/deny.
module pmp_multi_checker #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*ENTRIES-1:0]      pmpcfg,
    input  logic [XLEN*ENTRIES-1:0]   pmpaddr,
    pmp_multi_checker_if.slave        bus
);
    // Three extra bits keep NAPOT/TOR bounds and access ends free of wrap-around.
    localparam int W = XLEN + 3;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [XLEN-1:0]  addr_q;
    logic [1:0]       size_q;
    logic [1:0]       type_q;
    logic             priv_q;
    logic             allow_q;
    logic             match_q;
    logic [IDX_W-1:0] resp_idx_q;

    logic [7:0]       cfg_cur;
    logic [XLEN-1:0]  addr_cur;
    logic [XLEN-1:0]  addr_prev;
    logic [W-1:0]     lo_acc;
    logic [W-1:0]     hi_acc;
    logic [W-1:0]     reg_lo;
    logic [W-1:0]     reg_hi;
    logic             reg_nonempty;
    logic             entry_decides;
    logic             entry_contains;
    logic             perm_bit;
    logic             hit_allow;
    logic             miss_allow;
    logic             unused_cfg_bits;

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_allow = allow_q;
    assign bus.resp_match = match_q;
    assign bus.resp_idx   = resp_idx_q;

    // Select the entry under scan and its predecessor (TOR lower bound).
    always_comb begin
        int idx_i;
        int prev_i;
        idx_i     = int'(idx_q);
        prev_i    = (idx_q == '0) ? 0 : idx_i - 1;
        cfg_cur   = pmpcfg[8*idx_i +: 8];
        addr_cur  = pmpaddr[XLEN*idx_i +: XLEN];
        addr_prev = (idx_q == '0) ? '0 : pmpaddr[XLEN*prev_i +: XLEN];
    end

    assign unused_cfg_bits = ^cfg_cur[6:5];

    // Decode the current entry's region bounds from its address mode.
    always_comb begin
        int k;
        reg_lo       = '0;
        reg_hi       = '0;
        reg_nonempty = 1'b0;
        k            = XLEN;
        case (cfg_cur[4:3])
            2'b01: begin
                reg_lo       = {3'b000, addr_prev} << 2;
                reg_hi       = ({3'b000, addr_cur} << 2) - W'(1);
                reg_nonempty = (addr_prev < addr_cur);
            end
            2'b10: begin
                reg_lo       = {3'b000, addr_cur} << 2;
                reg_hi       = reg_lo + W'(3);
                reg_nonempty = 1'b1;
            end
            2'b11: begin
                // k = count of trailing ones = index of the lowest zero bit.
                for (int b = XLEN - 1; b >= 0; b--) begin
                    if (!addr_cur[b]) begin
                        k = b;
                    end
                end
                reg_lo       = ({3'b000, addr_cur} & ~((W'(1) << (k + 1)) - W'(1))) << 2;
                reg_hi       = reg_lo + (W'(1) << (k + 3)) - W'(1);
                reg_nonempty = 1'b1;
            end
            default: reg_nonempty = 1'b0;
        endcase
    end

    // Compare the access byte range against the region and resolve permissions.
    always_comb begin
        lo_acc         = {3'b000, addr_q};
        hi_acc         = lo_acc + (W'(1) << size_q) - W'(1);
        entry_decides  = reg_nonempty && (reg_lo <= hi_acc) && (lo_acc <= reg_hi);
        entry_contains = (reg_lo <= lo_acc) && (hi_acc <= reg_hi);
        case (type_q)
            2'b00:   perm_bit = cfg_cur[0];
            2'b01:   perm_bit = cfg_cur[1];
            2'b10:   perm_bit = cfg_cur[2];
            default: perm_bit = 1'b0;
        endcase
        hit_allow  = entry_contains && (type_q != 2'b11) &&
                     ((!cfg_cur[7] && priv_q) || perm_bit);
        miss_allow = priv_q && (type_q != 2'b11);
    end

    // Control FSM: accept, scan entries one per cycle, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            type_q     <= '0;
            priv_q     <= 1'b0;
            allow_q    <= 1'b0;
            match_q    <= 1'b0;
            resp_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        size_q  <= bus.req_size;
                        type_q  <= bus.req_type;
                        priv_q  <= bus.req_priv_m;
                        idx_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (entry_decides) begin
                        allow_q    <= hit_allow;
                        match_q    <= 1'b1;
                        resp_idx_q <= idx_q;
                        state_q    <= DONE;
                    end else if (idx_q == IDX_W'(ENTRIES - 1)) begin
                        allow_q    <= miss_allow;
                        match_q    <= 1'b0;
                        resp_idx_q <= IDX_W'(ENTRIES);
                        state_q    <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmp_multi_checker.sv
// Self-checking bench for pmp_multi_checker: a vector table of single-entry
// scenarios plus hand-written sequences for priority, back-pressure and reset.
module tb_pmp_multi_checker;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [8*ENTRIES-1:0]    cfg_vec  = '0;
    logic [XLEN*ENTRIES-1:0] addr_vec = '0;

    pmp_multi_checker_if #(.XLEN(XLEN), .ENTRIES(ENTRIES), .IDX_W(IDX_W)) bus ();

    pmp_multi_checker #(.XLEN(XLEN), .ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .pmpcfg  (cfg_vec),
        .pmpaddr (addr_vec),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       match;
        logic       allow;
        logic [4:0] idx;
        int         lat;
    } exp_t;

    typedef struct {
        string       name;
        int          e;
        logic [7:0]  cfg;
        logic [31:0] paddr;
        logic [31:0] prev;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [1:0]  ty;
        logic        pr;
        logic        m;
        logic        al;
        logic [4:0]  ix;
        int          lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[16];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_pmp();
        cfg_vec  = '0;
        addr_vec = '0;
    endtask

    task automatic start_req(input logic [31:0] a, input logic [1:0] sz,
                             input logic [1:0] ty, input logic pr);
        bus.req_addr   = a;
        bus.req_size   = sz;
        bus.req_type   = ty;
        bus.req_priv_m = pr;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
    endtask

    // Count edges from the accept edge (edge 1) until resp_valid is seen.
    task automatic wait_resp(output int lat, output bit got);
        lat = 1;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.resp_valid) got = 1'b1;
        end
    endtask

    task automatic recover();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_txn(input string nm, input logic [31:0] a, input logic [1:0] sz,
                          input logic [1:0] ty, input logic pr, input logic em,
                          input logic ea, input logic [4:0] ei, input int el);
        exp_t e;
        exp_t p;
        int   lat;
        bit   got;
        chk({nm, " req_ready before"}, 64'(bus.req_ready), 64'd1);
        start_req(a, sz, ty, pr);
        e = '{nm, em, ea, ei, el};
        sb_q.push_back(e);
        wait_resp(lat, got);
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got no resp_valid expected latency %0d", nm, el);
            sb_q.delete();
            recover();
            return;
        end
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got response expected none pending", nm);
        end else begin
            p = sb_q.pop_front();
            chk({p.name, " match"},   64'(bus.resp_match), 64'(p.match));
            chk({p.name, " allow"},   64'(bus.resp_allow), 64'(p.allow));
            chk({p.name, " idx"},     64'(bus.resp_idx),   64'(p.idx));
            chk({p.name, " latency"}, 64'(lat),            64'(p.lat));
            chk({p.name, " req_ready busy"}, 64'(bus.req_ready), 64'd0);
        end
        $display("txn %s: addr=%08h match=%0d allow=%0d idx=%0d lat=%0d",
                 nm, a, bus.resp_match, bus.resp_allow, bus.resp_idx, lat);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk({nm, " resp_valid drop"}, 64'(bus.resp_valid), 64'd0);
        chk({nm, " req_ready back"},  64'(bus.req_ready),  64'd1);
    endtask

    initial begin
        int  lat;
        bit  got;
        bit  stray;

        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_size   = '0;
        bus.req_type   = '0;
        bus.req_priv_m = 1'b0;
        bus.resp_ready = 1'b0;

        //          name        e  cfg    pmpaddr       prev          addr          sz     ty     pr m  al ix  lat
        vecs[0]  = '{"T1",      0, 8'h19, 32'h2000_03FF, 32'h0,       32'h8000_1FFC, 2'd2, 2'd0, 0, 1, 1, 0, 2};
        vecs[1]  = '{"T2",      0, 8'h19, 32'h2000_03FF, 32'h0,       32'h8000_1FFE, 2'd2, 2'd0, 0, 1, 0, 0, 2};
        vecs[2]  = '{"T3",      3, 8'h0F, 32'h0000_0800, 32'h400,     32'h0000_1FFF, 2'd0, 2'd1, 0, 1, 1, 3, 5};
        vecs[3]  = '{"T4M",     0, 8'h00, 32'h0,         32'h0,       32'h0000_0100, 2'd2, 2'd0, 1, 0, 1, 16, 17};
        vecs[4]  = '{"T4U",     0, 8'h00, 32'h0,         32'h0,       32'h0000_0100, 2'd2, 2'd0, 0, 0, 0, 16, 17};
        vecs[5]  = '{"NA4rd",   2, 8'h12, 32'h0000_0100, 32'h0,       32'h0000_0400, 2'd2, 2'd0, 0, 1, 0, 2, 4};
        vecs[6]  = '{"NA4wr",   2, 8'h12, 32'h0000_0100, 32'h0,       32'h0000_0400, 2'd2, 2'd1, 0, 1, 1, 2, 4};
        vecs[7]  = '{"MunlK",   1, 8'h18, 32'h2000_03FF, 32'h0,       32'h8000_0000, 2'd0, 2'd0, 1, 1, 1, 1, 3};
        vecs[8]  = '{"Mlock",   1, 8'h98, 32'h2000_03FF, 32'h0,       32'h8000_0000, 2'd0, 2'd0, 1, 1, 0, 1, 3};
        vecs[9]  = '{"RsvHit",  0, 8'h1F, 32'h2000_03FF, 32'h0,       32'h8000_0000, 2'd0, 2'd3, 1, 1, 0, 0, 2};
        vecs[10] = '{"RsvMiss", 0, 8'h00, 32'h0,         32'h0,       32'h8000_0000, 2'd0, 2'd3, 1, 0, 0, 16, 17};
        vecs[11] = '{"TOR0in",  0, 8'h09, 32'h0000_0400, 32'h0,       32'h0000_0FF8, 2'd3, 2'd0, 0, 1, 1, 0, 2};
        vecs[12] = '{"TOR0prt", 0, 8'h09, 32'h0000_0400, 32'h0,       32'h0000_0FFC, 2'd3, 2'd0, 0, 1, 0, 0, 2};
        vecs[13] = '{"TORempt", 4, 8'h0F, 32'h0000_0400, 32'h800,     32'h0000_1000, 2'd2, 2'd0, 0, 0, 0, 16, 17};
        vecs[14] = '{"NAPall",  7, 8'h1C, 32'hFFFF_FFFF, 32'h0,       32'hFFFF_FFFC, 2'd2, 2'd2, 0, 1, 1, 7, 9};
        vecs[15] = '{"NA4past", 2, 8'h12, 32'h0000_0100, 32'h0,       32'h0000_0404, 2'd0, 2'd0, 0, 0, 0, 16, 17};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready",  64'(bus.req_ready),  64'd1);
        chk("reset resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("reset resp_allow", 64'(bus.resp_allow), 64'd0);
        chk("reset resp_match", 64'(bus.resp_match), 64'd0);
        chk("reset resp_idx",   64'(bus.resp_idx),   64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven single-entry scenarios.
        for (int v = 0; v < 16; v++) begin
            clear_pmp();
            cfg_vec[8*vecs[v].e +: 8]        = vecs[v].cfg;
            addr_vec[XLEN*vecs[v].e +: XLEN] = vecs[v].paddr;
            if (vecs[v].e > 0) addr_vec[XLEN*(vecs[v].e-1) +: XLEN] = vecs[v].prev;
            do_txn(vecs[v].name, vecs[v].addr, vecs[v].sz, vecs[v].ty, vecs[v].pr,
                   vecs[v].m, vecs[v].al, vecs[v].ix, vecs[v].lat);
        end

        // T5: two overlapping NAPOT entries; locked entry 1 wins even for M.
        clear_pmp();
        cfg_vec[8*1 +: 8]     = 8'h98;
        addr_vec[XLEN*1 +: XLEN] = 32'h0000_003F;
        cfg_vec[8*5 +: 8]     = 8'h19;
        addr_vec[XLEN*5 +: XLEN] = 32'h0000_003F;
        do_txn("T5", 32'h0000_0100, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 5'd1, 3);

        // T6a: hold resp_ready low; result stable, no second request taken.
        clear_pmp();
        cfg_vec[8*0 +: 8]        = 8'h19;
        addr_vec[XLEN*0 +: XLEN] = 32'h2000_03FF;
        start_req(32'h8000_1FFC, 2'd2, 2'd0, 1'b0);
        wait_resp(lat, got);
        chk("T6 resp seen", 64'(got), 64'd1);
        bus.req_addr  = 32'h0000_0000;
        bus.req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("T6 hold resp_valid", 64'(bus.resp_valid), 64'd1);
            chk("T6 hold allow",      64'(bus.resp_allow), 64'd1);
            chk("T6 hold match",      64'(bus.resp_match), 64'd1);
            chk("T6 hold idx",        64'(bus.resp_idx),   64'd0);
            chk("T6 hold req_ready",  64'(bus.req_ready),  64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        chk("T6 release req_ready",  64'(bus.req_ready),  64'd1);
        chk("T6 release resp_valid", 64'(bus.resp_valid), 64'd0);
        $display("txn T6hold: resp held 4 cycles, released");

        // T6b: reset mid-scan abandons the request.
        clear_pmp();
        start_req(32'h0000_0100, 2'd2, 2'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("T6 rst req_ready",  64'(bus.req_ready),  64'd1);
        chk("T6 rst resp_valid", 64'(bus.resp_valid), 64'd0);
        stray = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) stray = 1'b1;
        end
        chk("T6 rst no response", 64'(stray), 64'd0);
        $display("txn T6rst: scan abandoned by reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
